// File: rtl/cpu_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_pkg - shared CPU constants, opcodes and fetch state encoding   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_halt_ctrl.sv
// +--------------------------------------------------------------------+
// | fetch_halt_ctrl - halt acceptance, pipeline drain count, halt flag |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_halt_ctrl
   import cpu_pkg::*;
#(
   parameter int DRAIN_CYCLES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         redirect_valid,
   input  logic         halt_req,
   output fetch_state_t state,
   output logic         is_halted
);

   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   fetch_state_t  state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          halted_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_RUN;
         cnt       <= '0;
         is_halted <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         is_halted <= halted_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      halted_nxt = is_halted;
      case (state)
         ST_RUN: begin
            // Redirect and stall both outrank a halt request.
            if (halt_req && !stall && !redirect_valid) begin
               state_nxt = ST_DRAIN;
               cnt_nxt   = CW'(DRAIN_CYCLES - 1);
            end
         end
         ST_DRAIN: begin
            if (cnt == '0) begin
               state_nxt  = ST_HALTED;
               halted_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_HALTED: begin
            halted_nxt = 1'b1;
         end
         default: begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// +--------------------------------------------------------------------+
// | fetch_stage - PC register, IF/ID pipeline register, halt sequencing |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          DRAIN_CYCLES = 4,
   parameter logic [31:0] NOP_INST     = cpu_pkg::NOP_INST
) (
   input  logic        reset,
   input  logic        clk,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_dout,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc,
   output logic        if_id_valid,
   output logic        is_halted
);

   fetch_state_t state;
   logic [31:0]  pc;

   fetch_halt_ctrl #(
      .DRAIN_CYCLES(DRAIN_CYCLES)
   ) u_halt_ctrl (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .redirect_valid(redirect_valid),
      .halt_req      (halt_req),
      .state         (state),
      .is_halted     (is_halted)
   );

   assign imem_addr = pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         if_id_inst  <= NOP_INST;
         if_id_pc    <= '0;
         if_id_valid <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (redirect_valid) begin
                  pc          <= redirect_pc;
                  if_id_inst  <= NOP_INST;
                  if_id_pc    <= '0;
                  if_id_valid <= 1'b0;
               end else if (!stall) begin
                  if (halt_req) begin
                     // Halt accepted: PC freezes, bubble starts the drain.
                     if_id_inst  <= NOP_INST;
                     if_id_pc    <= '0;
                     if_id_valid <= 1'b0;
                  end else begin
                     pc          <= pc + 32'd4;
                     if_id_inst  <= imem_dout;
                     if_id_pc    <= pc;
                     if_id_valid <= 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if_id_inst  <= NOP_INST;
               if_id_pc    <= '0;
               if_id_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// +--------------------------------------------------------------------+
// | tb_fetch_stage - directed vector bench for fetch_stage             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_dout;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc;
   logic        if_id_valid;
   logic        is_halted;

   int n_checks = 0;
   int n_fails  = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] I1  = 32'h0010_0093;

   fetch_stage #(
      .RESET_PC    (32'h0000_0000),
      .DRAIN_CYCLES(4),
      .NOP_INST    (32'h0000_0013)
   ) dut (
      .reset         (reset),
      .clk           (clk),
      .stall         (stall),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .halt_req      (halt_req),
      .imem_addr     (imem_addr),
      .imem_dout     (imem_dout),
      .if_id_inst    (if_id_inst),
      .if_id_pc      (if_id_pc),
      .if_id_valid   (if_id_valid),
      .is_halted     (is_halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        rv;
      logic [31:0] rpc;
      logic        halt;
      logic [31:0] dout;
      logic [31:0] e_addr;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
      logic        e_valid;
      logic        e_halted;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] a, input logic [31:0] ins,
                          input logic [31:0] p, input logic v, input logic h);
      chk({tag, "_addr"},   imem_addr,          a);
      chk({tag, "_inst"},   if_id_inst,         ins);
      chk({tag, "_pc"},     if_id_pc,           p);
      chk({tag, "_valid"},  {31'd0, if_id_valid}, {31'd0, v});
      chk({tag, "_halted"}, {31'd0, is_halted},   {31'd0, h});
   endtask

   task automatic drive(input logic s, input logic rv, input logic [31:0] rpc,
                        input logic h, input logic [31:0] d);
      stall = s; redirect_valid = rv; redirect_pc = rpc; halt_req = h; imem_dout = d;
   endtask

   task automatic step_free(input logic [31:0] d);
      drive(1'b0, 1'b0, 32'h0, 1'b0, d);
      @(posedge clk); #1;
   endtask

   initial begin
      //           stall rv rpc           halt dout          addr          inst          pc            v  h
      vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, I1,           32'h4,        I1,           32'h0,        1'b1, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, I1,           32'h8,        I1,           32'h4,        1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 32'h8,        I1,           32'h4,        1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 32'h8,        I1,           32'h4,        1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h00200113, 32'hC,        32'h00200113, 32'h8,        1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 32'h40,       1'b1, 32'hDEADBEEF, 32'h40,       NOP,          32'h0,        1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h00300193, 32'h44,       32'h00300193, 32'h40,       1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'hDEADBEEF, 32'hFFFFFFFC, NOP,          32'h0,        1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h11111111, 32'h0,        32'h11111111, 32'hFFFFFFFC, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h22222222, 32'h4,        32'h22222222, 32'h0,        1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 32'h10,       1'b0, 32'hDEADBEEF, 32'h10,       NOP,          32'h0,        1'b0, 1'b0};
      // halt accepted at pc 0x10; is_halted expected on the 4th edge after
      vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h33333333, 32'h10,       NOP,          32'h0,        1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 32'h80,       1'b0, 32'h44444444, 32'h10,       NOP,          32'h0,        1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h44444444, 32'h10,       NOP,          32'h0,        1'b0, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h44444444, 32'h10,       NOP,          32'h0,        1'b0, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h44444444, 32'h10,       NOP,          32'h0,        1'b0, 1'b1};
      vecs[16] = '{1'b1, 1'b1, 32'h100,      1'b1, 32'h55555555, 32'h10,       NOP,          32'h0,        1'b0, 1'b1};

      reset = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 1'b0, I1);
      #2;
      chk_all("reset", 32'h0, NOP, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk_all("first", 32'h4, I1, 32'h0, 1'b1, 1'b0);

      // Restart so the table begins from pc 0 with a clean reset state.
      reset = 1'b1; #1; reset = 1'b0;
      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].halt, vecs[i].dout);
         @(posedge clk); #1;
         chk_all($sformatf("v%0d", i), vecs[i].e_addr, vecs[i].e_inst,
                 vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_halted);
      end

      // Asynchronous reset while HALTED, then fetch resumes from RESET_PC.
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk_all("rst_halted", 32'h0, NOP, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      step_free(I1);
      step_free(I1);
      chk_all("resume", 32'h8, I1, 32'h4, 1'b1, 1'b0);

      // Accept a halt, then abort mid-drain with reset between edges.
      drive(1'b0, 1'b0, 32'h0, 1'b1, I1);
      @(posedge clk); #1;
      step_free(I1);
      chk_all("drain", 32'h8, NOP, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk_all("rst_drain", 32'h0, NOP, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step_free(32'h0100_0000 + 32'(k));
         chk_all($sformatf("post_abort%0d", k), 32'(4 * k), 32'h0100_0000 + 32'(k),
                 32'(4 * (k - 1)), 1'b1, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL provide parameter DRAIN_CYCLES, default 4, number of clock edges after halt acceptance before is_halted rises (ID, EX, MEM, WB drain).
REQ-003 SHALL provide parameter NOP_INST, default 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-004 SHALL provide ports as follows:
- reset  input  1  asynchronous, active-high
- clk  input  1  single clock, all state updates on rising edge
- stall  input  1  hazard hold: freeze PC and IF/ID
- redirect_valid  input  1  branch/jump resolved taken in EX
- redirect_pc  input  32  redirect target
- halt_req  input  1  ecall decoded in ID with halt condition true
- imem_addr  output  32  current PC to InstMemory (combinational read)
- imem_dout  input  32  instruction at imem_addr, same cycle
- if_id_inst  output  32  IF/ID instruction register
- if_id_pc  output  32  IF/ID PC register
- if_id_valid  output  1  IF/ID holds a real instruction
- is_halted  output  1  registered, sticky halt indication

Function
REQ-005 SHALL drive imem_addr directly from the PC register.
REQ-006 SHALL implement states RUN, DRAIN, HALTED.
REQ-007 RUN, no stall/redirect/halt_req: each edge SHALL load pc<=pc+4 (modulo 2^32), if_id_inst<=imem_dout, if_id_pc<=pc, if_id_valid<=1.
REQ-008 RUN, stall=1, redirect_valid=0: SHALL hold pc, if_id_inst, if_id_pc, if_id_valid unchanged.
REQ-009 RUN, redirect_valid=1: SHALL load pc<=redirect_pc, if_id_inst<=NOP_INST, if_id_pc<=0, if_id_valid<=0, regardless of stall and halt_req.
REQ-010 Priority SHALL be reset > redirect_valid > stall > halt_req.
REQ-011 halt_req SHALL be accepted only in RUN with stall=0 and redirect_valid=0; on acceptance: state<=DRAIN, drain counter<=DRAIN_CYCLES-1, pc held, IF/ID loaded with bubble (NOP_INST, pc 0, valid 0).
REQ-012 DRAIN: SHALL hold pc, insert bubbles into IF/ID every edge, ignore stall, redirect_valid, halt_req; decrement counter each edge.
REQ-013 DRAIN with counter==0: next edge SHALL enter HALTED and set is_halted<=1, so is_halted rises exactly DRAIN_CYCLES edges after the accepting edge.
REQ-014 HALTED: SHALL hold all outputs constant, ignore all inputs except reset; is_halted stays 1.
REQ-015 redirect_pc SHALL be used unmodified; no alignment check.

Reset
REQ-016 reset=1 SHALL immediately, without a clock edge, force pc=RESET_PC, if_id_inst=NOP_INST, if_id_pc=0, if_id_valid=0, is_halted=0, state=RUN, drain counter=0.
REQ-017 Reset asserted mid-DRAIN or in HALTED SHALL abort the halt sequence completely.
REQ-018 First fetch after reset deassertion SHALL be from RESET_PC on the first rising edge.

Structure
REQ-019 NOP_INST value, fetch state enum typedef, and opcode constants SHALL reside in shared package cpu_pkg.
REQ-020 Halt drain state machine and counter SHALL be one sub-module, fetch_halt_ctrl; PC and IF/ID registers SHALL stay in fetch_stage.

Verification
REQ-021 Reset, then 3 free-run edges with imem returning 0x00100093 -> imem_addr 0,4,8,12; if_id_pc 0,4,8; if_id_valid 1 after first edge.
REQ-022 stall=1 for 2 edges at pc=0x8 -> imem_addr stays 0x8, if_id_pc stays 0x4, if_id_inst unchanged.
REQ-023 redirect_valid=1, redirect_pc=0x40, stall=1, halt_req=1 same cycle -> next imem_addr 0x40, if_id_inst 0x13, if_id_valid 0, state RUN.
REQ-024 halt_req accepted at pc=0x10 -> is_halted 1 exactly 4 edges later; imem_addr stays 0x10; redirect to 0x80 during DRAIN ignored.
REQ-025 redirect_pc=0xFFFFFFFC, then free run -> imem_addr 0xFFFFFFFC then 0x00000000.
REQ-026 Assert reset asynchronously mid-DRAIN between edges -> imem_addr 0, is_halted 0, if_id_valid 0 before next edge.
